// File: rtl/ball_slot_scheduler.sv
// Falling-ball slot scheduler: per-frame scan (cut, physics, exit), spawn cadence, score/lives.
// Optional BALL_SLOT_COMBO_EN: every cut after the first in the same frame scores +2.
module ball_slot_scheduler #(
   parameter int unsigned NUM_BALLS    = 4,
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned HIT_R        = 24,
   parameter int unsigned SPAWN_PERIOD = 60,
   parameter int unsigned GRAVITY      = 1,
   parameter int unsigned IW           = $clog2(NUM_BALLS)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_frame_end,
   input  logic          i_blade_valid,
   input  logic [10:0]   i_blade_x,
   input  logic [10:0]   i_blade_y,
   input  logic [15:0]   i_rand,
   input  logic [IW-1:0] i_rd_idx,
   output logic [10:0]   o_rd_x,
   output logic [10:0]   o_rd_y,
   output logic          o_rd_alive,
   output logic          o_busy,
   output logic          o_update_done,
   output logic [20:0]   o_score,
   output logic [1:0]    o_life,
   output logic          o_game_over
);

   localparam int unsigned FW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
   localparam logic [20:0] SCORE_MAX = '1;
   localparam logic signed [11:0] HIT_R_S = 12'(HIT_R);
   localparam logic signed [11:0] SW_S    = 12'(SCREEN_W);
   localparam logic signed [11:0] SH_S    = 12'(SCREEN_H);
   localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);

   typedef enum logic [1:0] {StIdle, StScan, StSpawn, StDone} state_e;

   state_e               state_q, state_d;
   logic [10:0]          x_q  [NUM_BALLS];
   logic [10:0]          x_d  [NUM_BALLS];
   logic [10:0]          y_q  [NUM_BALLS];
   logic [10:0]          y_d  [NUM_BALLS];
   logic [5:0]           vx_q [NUM_BALLS];
   logic [5:0]           vx_d [NUM_BALLS];
   logic [5:0]           vy_q [NUM_BALLS];
   logic [5:0]           vy_d [NUM_BALLS];
   logic [NUM_BALLS-1:0] alive_q, alive_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [20:0]          score_q, score_d;
   logic [1:0]           life_q, life_d;
   logic                 game_over_q, game_over_d;
   logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
`ifdef BALL_SLOT_COMBO_EN
   logic [IW:0]          cut_cnt_q, cut_cnt_d;
`endif

   // Datapath for the slot currently addressed by the scan index.
   logic signed [11:0] cur_x, cur_y, dx, dy, adx, ady, nx, ny;
   logic signed [7:0]  vy_inc, nvy;
   logic               cut, exits;
   logic [20:0]        score_inc;
   logic               found;
   logic [IW-1:0]      free_idx;
   logic [10:0]        spawn_x;
   logic [5:0]         spawn_vx, spawn_vy;

   always_comb begin
      cur_x  = $signed({1'b0, x_q[idx_q]});
      cur_y  = $signed({1'b0, y_q[idx_q]});
      dx     = $signed({1'b0, i_blade_x}) - cur_x;
      dy     = $signed({1'b0, i_blade_y}) - cur_y;
      adx    = (dx < 12'sd0) ? -dx : dx;
      ady    = (dy < 12'sd0) ? -dy : dy;
      cut    = i_blade_valid && (adx <= HIT_R_S) && (ady <= HIT_R_S);
      nx     = cur_x + $signed({{6{vx_q[idx_q][5]}}, vx_q[idx_q]});
      ny     = cur_y + $signed({{6{vy_q[idx_q][5]}}, vy_q[idx_q]});
      vy_inc = $signed({{2{vy_q[idx_q][5]}}, vy_q[idx_q]}) + GRAV_S;
      nvy    = (vy_inc > 8'sd31) ? 8'sd31 : vy_inc;
      // Ball hitting the top edge stops there and starts falling from rest.
      if (ny < 12'sd0) begin
         ny  = 12'sd0;
         nvy = 8'sd0;
      end
      exits  = (nx < 12'sd0) || (nx >= SW_S) || (ny >= SH_S);
   end

   always_comb begin
      found    = 1'b0;
      free_idx = '0;
      for (int i = NUM_BALLS - 1; i >= 0; i--) begin
         if (!alive_q[i]) begin
            found    = 1'b1;
            free_idx = IW'(i);
         end
      end
      spawn_x  = 11'd64 + {2'b00, i_rand[8:0]};
      spawn_vx = {{2{i_rand[12]}}, i_rand[12:9]};
      spawn_vy = 6'd0 - (6'd16 + {3'b000, i_rand[15:13]});
   end

`ifdef BALL_SLOT_COMBO_EN
   assign score_inc = (cut_cnt_q != '0) ? 21'd2 : 21'd1;
`else
   assign score_inc = 21'd1;
`endif

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      vx_d        = vx_q;
      vy_d        = vy_q;
      alive_d     = alive_q;
      idx_d       = idx_q;
      score_d     = score_q;
      life_d      = life_q;
      game_over_d = game_over_q;
      frame_cnt_d = frame_cnt_q;
`ifdef BALL_SLOT_COMBO_EN
      cut_cnt_d   = cut_cnt_q;
`endif

      case (state_q)
         StIdle: begin
`ifdef BALL_SLOT_COMBO_EN
            cut_cnt_d = '0;
`endif
            if (i_frame_end && !game_over_q) begin
               state_d = StScan;
               idx_d   = '0;
            end
         end
         StScan: begin
            if (idx_q == IW'(NUM_BALLS - 1)) state_d = StSpawn;
            else                             idx_d   = idx_q + 1'b1;
            if (alive_q[idx_q]) begin
               if (cut) begin
                  alive_d[idx_q] = 1'b0;
                  score_d = (score_q > SCORE_MAX - score_inc) ? SCORE_MAX : score_q + score_inc;
`ifdef BALL_SLOT_COMBO_EN
                  cut_cnt_d = cut_cnt_q + 1'b1;
`endif
               end else if (exits) begin
                  alive_d[idx_q] = 1'b0;
                  life_d         = life_q - 2'd1;
                  if (life_q == 2'd1) begin
                     game_over_d = 1'b1;
                     state_d     = StDone;
                  end
               end else begin
                  x_d[idx_q]  = nx[10:0];
                  y_d[idx_q]  = ny[10:0];
                  vy_d[idx_q] = nvy[5:0];
               end
            end
         end
         StSpawn: begin
            state_d = StDone;
            if (frame_cnt_q == FW'(SPAWN_PERIOD - 1)) begin
               frame_cnt_d = '0;
               if (found) begin
                  x_d[free_idx]     = spawn_x;
                  y_d[free_idx]     = 11'(SCREEN_H - 1);
                  vx_d[free_idx]    = spawn_vx;
                  vy_d[free_idx]    = spawn_vy;
                  alive_d[free_idx] = 1'b1;
               end
            end else begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Restart wins over everything, including an update in flight.
      if (i_start) begin
         state_d     = StIdle;
         alive_d     = '0;
         idx_d       = '0;
         score_d     = '0;
         life_d      = 2'd3;
         game_over_d = 1'b0;
         frame_cnt_d = '0;
         for (int i = 0; i < NUM_BALLS; i++) begin
            x_d[i]  = '0;
            y_d[i]  = '0;
            vx_d[i] = '0;
            vy_d[i] = '0;
         end
`ifdef BALL_SLOT_COMBO_EN
         cut_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         alive_q     <= '0;
         idx_q       <= '0;
         score_q     <= '0;
         life_q      <= 2'd3;
         game_over_q <= 1'b0;
         frame_cnt_q <= '0;
         for (int i = 0; i < NUM_BALLS; i++) begin
            x_q[i]  <= '0;
            y_q[i]  <= '0;
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
`ifdef BALL_SLOT_COMBO_EN
         cut_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         alive_q     <= alive_d;
         idx_q       <= idx_d;
         score_q     <= score_d;
         life_q      <= life_d;
         game_over_q <= game_over_d;
         frame_cnt_q <= frame_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         vx_q        <= vx_d;
         vy_q        <= vy_d;
`ifdef BALL_SLOT_COMBO_EN
         cut_cnt_q   <= cut_cnt_d;
`endif
      end
   end

   assign o_rd_x        = x_q[i_rd_idx];
   assign o_rd_y        = y_q[i_rd_idx];
   assign o_rd_alive    = alive_q[i_rd_idx];
   assign o_busy        = (state_q != StIdle);
   assign o_update_done = (state_q == StDone);
   assign o_score       = score_q;
   assign o_life        = life_q;
   assign o_game_over   = game_over_q;

endmodule

// File: tb/tb_ball_slot_scheduler.sv
// Scoreboard bench for ball_slot_scheduler: stimulus pushes expected frame results, a monitor
// checks them on each update-done pulse (and on idle snapshot requests).
module tb_ball_slot_scheduler;

   logic        clk = 1'b0;
   logic        rst_n, start, frame_end, blade_valid;
   logic [10:0] blade_x, blade_y;
   logic [15:0] rand_w;
   logic [1:0]  rd_idx = '0;
   logic [10:0] rd_x, rd_y;
   logic        rd_alive, busy, update_done, game_over;
   logic [20:0] score;
   logic [1:0]  life;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ball_slot_scheduler #(
      .NUM_BALLS(4), .SCREEN_W(640), .SCREEN_H(480), .HIT_R(24), .SPAWN_PERIOD(4), .GRAVITY(1)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_end(frame_end),
      .i_blade_valid(blade_valid), .i_blade_x(blade_x), .i_blade_y(blade_y), .i_rand(rand_w),
      .i_rd_idx(rd_idx), .o_rd_x(rd_x), .o_rd_y(rd_y), .o_rd_alive(rd_alive), .o_busy(busy),
      .o_update_done(update_done), .o_score(score), .o_life(life), .o_game_over(game_over)
   );

   typedef struct {
      int               tag;
      int               t_issue;
      int               lat;
      bit               chk_top;
      int               score;
      int               life;
      bit               go;
      logic [3:0]       smask;
      logic [3:0]       a;
      logic [3:0][10:0] x;
      logic [3:0][10:0] y;
   } exp_t;

   exp_t exp_q[$];
   exp_t idle_q[$];
   exp_t mon_e;
   bit   mon_have, mon_done;
   int   hand_tag = 1000;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Small integer reference model of the slot game.
   int mx[4], my[4], mvx[4], mvy[4];
   bit ma[4];
   int mscore, mlife, mcnt, mframe;
   bit mgo;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; ma[i] = 0;
      end
      mscore = 0; mlife = 3; mcnt = 0; mgo = 0;
   endtask

   task automatic model_fill(output exp_t e);
      e.chk_top = 1; e.score = mscore; e.life = mlife; e.go = mgo; e.smask = 4'hF;
      e.lat = 6; e.t_issue = 0; e.tag = mframe;
      for (int i = 0; i < 4; i++) begin
         e.a[i] = ma[i]; e.x[i] = 11'(mx[i]); e.y[i] = 11'(my[i]);
      end
   endtask

   task automatic model_frame(input bit bv, input int bx, input int by, input logic [15:0] r,
                              output exp_t e);
      int nx, ny, nvy, cuts, add, lat, v4;
      bit stop, placed;
      stop = 0; cuts = 0; lat = 6; mframe++;
      for (int i = 0; i < 4; i++) begin
         if (!stop && ma[i]) begin
            if (bv && iabs(bx - mx[i]) <= 24 && iabs(by - my[i]) <= 24) begin
               ma[i] = 0;
               add = 1;
`ifdef BALL_SLOT_COMBO_EN
               if (cuts > 0) add = 2;
`endif
               cuts++;
               mscore = (mscore + add > 2097151) ? 2097151 : mscore + add;
            end else begin
               nx = mx[i] + mvx[i]; ny = my[i] + mvy[i];
               nvy = (mvy[i] + 1 > 31) ? 31 : mvy[i] + 1;
               if (ny < 0) begin ny = 0; nvy = 0; end
               if (nx < 0 || nx >= 640 || ny >= 480) begin
                  ma[i] = 0; mlife--;
                  if (mlife == 0) begin mgo = 1; stop = 1; lat = i + 2; end
               end else begin
                  mx[i] = nx; my[i] = ny; mvy[i] = nvy;
               end
            end
         end
      end
      if (!stop) begin
         if (mcnt == 3) begin
            mcnt = 0; placed = 0;
            for (int j = 0; j < 4; j++) begin
               if (!placed && !ma[j]) begin
                  placed = 1;
                  v4 = int'(r[12:9]);
                  mx[j] = 64 + int'(r[8:0]); my[j] = 479;
                  mvx[j] = (v4 >= 8) ? v4 - 16 : v4;
                  mvy[j] = -(16 + int'(r[15:13]));
                  ma[j] = 1;
               end
            end
         end else mcnt++;
      end
      model_fill(e);
      e.lat = lat;
   endtask

   // Monitor: owns rd_idx, compares on update_done or on an idle snapshot request.
   always @(negedge clk) begin
      mon_have = 0;
      mon_done = update_done;
      if (update_done) begin
         if (exp_q.size() == 0) chk("unexpected_update_done", 1, 0);
         else begin mon_e = exp_q.pop_front(); mon_have = 1; end
      end else if (idle_q.size() != 0) begin
         mon_e = idle_q.pop_front(); mon_have = 1;
      end
      if (mon_have) begin
         if (mon_done) chk($sformatf("rec%0d done_latency", mon_e.tag), cyc - mon_e.t_issue, mon_e.lat);
         if (mon_e.chk_top) begin
            chk($sformatf("rec%0d score", mon_e.tag), int'(score), mon_e.score);
            chk($sformatf("rec%0d life", mon_e.tag), int'(life), mon_e.life);
            chk($sformatf("rec%0d game_over", mon_e.tag), int'(game_over), int'(mon_e.go));
         end
         for (int k = 0; k < 4; k++) begin
            if (mon_e.smask[k]) begin
               rd_idx = 2'(k);
               #1;
               chk($sformatf("rec%0d s%0d alive", mon_e.tag, k), int'(rd_alive), int'(mon_e.a[k]));
               chk($sformatf("rec%0d s%0d x", mon_e.tag, k), int'(rd_x), int'(mon_e.x[k]));
               chk($sformatf("rec%0d s%0d y", mon_e.tag, k), int'(rd_y), int'(mon_e.y[k]));
            end
         end
      end
   end

   task automatic wait_idle_q();
      for (int i = 0; i < 10 && idle_q.size() != 0; i++) @(posedge clk);
      if (idle_q.size() != 0) begin
         chk("idle_snapshot_timeout", 1, 0);
         idle_q.delete();
      end
   endtask

   // Hand-computed expectation on one slot (s<0: top-level values only).
   task automatic hand(input int s, input bit a, input int x, input int y,
                       input int sc, input int lf, input bit go);
      exp_t e;
      e.tag = hand_tag++; e.t_issue = 0; e.lat = 0; e.chk_top = 1;
      e.score = sc; e.life = lf; e.go = go; e.smask = '0; e.a = '0; e.x = '0; e.y = '0;
      if (s >= 0) begin
         e.smask[s] = 1'b1; e.a[s] = a; e.x[s] = 11'(x); e.y[s] = 11'(y);
      end
      idle_q.push_back(e);
      wait_idle_q();
   endtask

   task automatic check_all_clear();
      exp_t e;
      e.tag = hand_tag++; e.t_issue = 0; e.lat = 0; e.chk_top = 1;
      e.score = 0; e.life = 3; e.go = 0; e.smask = 4'hF; e.a = '0; e.x = '0; e.y = '0;
      idle_q.push_back(e);
      wait_idle_q();
   endtask

   task automatic do_frame(input bit bv, input int bx, input int by, input logic [15:0] r,
                           input bit extra);
      exp_t e;
      bit   was_go, seen_busy;
      was_go = mgo;
      @(negedge clk);
      blade_valid = bv; blade_x = 11'(bx); blade_y = 11'(by); rand_w = r; frame_end = 1'b1;
      if (!was_go) begin
         model_frame(bv, bx, by, r, e);
         e.t_issue = cyc;
         exp_q.push_back(e);
      end
      @(negedge clk);
      frame_end = 1'b0;
      if (was_go) begin
         seen_busy = busy;
         repeat (8) begin @(negedge clk); seen_busy |= busy; end
         chk("busy_after_game_over", int'(seen_busy), 0);
      end else begin
         chk("busy_after_pulse", int'(busy), 1);
         if (extra) begin
            frame_end = 1'b1;
            @(negedge clk);
            frame_end = 1'b0;
         end
         for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
         if (exp_q.size() != 0) begin
            chk("update_done_timeout", 1, 0);
            exp_q.delete();
         end
         @(negedge clk);
         chk("busy_after_done", int'(busy), 0);
      end
      blade_valid = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      model_reset();
      check_all_clear();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout got 1 expected 0");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      rst_n = 1'b0; start = 1'b0; frame_end = 1'b0; blade_valid = 1'b0;
      blade_x = '0; blade_y = '0; rand_w = '0;
      mframe = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_update_done", int'(update_done), 0);
      chk("reset_life", int'(life), 3);
      chk("reset_score", int'(score), 0);
      check_all_clear();

      // Spawn cadence, first move, cut, no-cut, blade_valid gating, ignored busy pulse.
      for (int f = 1; f <= 4; f++) do_frame(0, 0, 0, 16'h46A0, 0);
      hand(0, 1, 224, 479, 0, 3, 0);
      do_frame(0, 0, 0, 16'h46A0, 0);
      hand(0, 1, 227, 461, 0, 3, 0);
      do_frame(1, 230, 470, 16'h46A0, 0);
      hand(0, 0, 227, 461, 1, 3, 0);
      do_frame(0, 0, 0, 16'h46A0, 0);
      do_frame(0, 0, 0, 16'h46A0, 0);
      hand(0, 1, 224, 479, 1, 3, 0);
      do_frame(1, 260, 461, 16'h46A0, 0);
      hand(0, 1, 227, 461, 1, 3, 0);
      do_frame(0, 227, 461, 16'h46A0, 1);
      hand(0, 1, 230, 444, 1, 3, 0);

      // Restart during the scan discards the update.
      @(negedge clk); frame_end = 1'b1;
      @(negedge clk); frame_end = 1'b0;
      chk("scan_busy_before_start", int'(busy), 1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_busy", int'(busy), 0);
      chk("start_update_done", int'(update_done), 0);
      model_reset();
      check_all_clear();

      // Left exits drain lives; two balls leave in frame 29, the second is left untouched.
      for (int f = 1; f <= 29; f++) begin
         r = (f == 4 || f == 8 || f == 20) ? 16'h1000 : (f == 12) ? 16'h1800 : 16'h0000;
         do_frame(0, 0, 0, r, 0);
         if (f == 13) hand(-1, 0, 0, 0, 0, 2, 0);
         if (f == 17) hand(-1, 0, 0, 0, 0, 1, 0);
      end
      hand(1, 0, 0, 379, 0, 0, 1);
      hand(2, 1, 0, 343, 0, 0, 1);
      hand(3, 1, 64, 421, 0, 0, 1);
      do_frame(0, 0, 0, 16'h0000, 0);
      do_frame(0, 0, 0, 16'h0000, 0);
      chk("game_over_held", int'(game_over), 1);

      // Bottom exit after a full rise and fall.
      do_start();
      for (int f = 1; f <= 38; f++) begin
         do_frame(0, 0, 0, 16'h0000, 0);
         if (f == 37) hand(0, 1, 64, 479, 0, 3, 0);
      end
      hand(0, 0, 64, 479, 0, 2, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_slot_scheduler.md
Name: ball_slot_scheduler

Overview:
Per-frame controller for the falling-ball game datapath. It owns NUM_BALLS ball slots holding position, velocity and alive state. On each frame-end pulse it walks the slots one per cycle: blade cut test, physics update, off-screen check. It then spawns a ball on a fixed frame cadence and maintains score, lives and game-over for the VGA renderer and game FSM.

Parameters:
NUM_BALLS, 4, number of slots (2..8); slot index width IW = clog2(NUM_BALLS)
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
HIT_R, 24, cut half-window in pixels (Chebyshev distance)
SPAWN_PERIOD, 60, frames between spawn attempts (>=1)
GRAVITY, 1, vy increment per frame

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_start  in  1  pulse: clear game (any state)
i_frame_end  in  1  pulse: one frame finished
i_blade_valid  in  1  blade point valid this frame
i_blade_x  in  11  blade x
i_blade_y  in  11  blade y
i_rand  in  16  free-running random word
i_rd_idx  in  IW  renderer slot select
o_rd_x  out  11  x of selected slot (combinational)
o_rd_y  out  11  y of selected slot (combinational)
o_rd_alive  out  1  alive of selected slot (combinational)
o_busy  out  1  update in progress
o_update_done  out  1  one-cycle pulse at end of update
o_score  out  21  score
o_life  out  2  remaining lives
o_game_over  out  1  lives exhausted

Behaviour:
- Reset: all slots alive=0, x=y=0, vx=vy=0; o_score=0, o_life=3, o_game_over=0, frame_cnt=0, state S_IDLE, o_busy=0, o_update_done=0.
- i_start (any state, highest priority): next cycle same values as reset. An in-flight update is discarded.
- FSM S_IDLE -> S_SCAN -> S_SPAWN -> S_DONE -> S_IDLE.
- S_IDLE: i_frame_end with !o_game_over -> S_SCAN, idx=0. i_frame_end is ignored when busy or game over (the frame is dropped).
- Timing: i_frame_end sampled at cycle t. Scan runs t+1..t+NUM_BALLS. S_SPAWN at t+NUM_BALLS+1. o_update_done pulses at t+NUM_BALLS+2. o_busy is high t+1..t+NUM_BALLS+2.
- S_SCAN, per alive slot (dead slots skipped, still 1 cycle):
  - Cut test uses pre-move position: i_blade_valid && |bx-x|<=HIT_R && |by-y|<=HIT_R.
  - On a cut: alive=0, score+1 (saturate at 2^21-1), no move.
  - Otherwise, 12-bit signed: nx=x+sext(vx), ny=y+sext(vy), nvy=min(vy+GRAVITY,+31).
  - If ny<0: ny=0 and nvy=0.
  - If nx<0, nx>=SCREEN_W or ny>=SCREEN_H: alive=0 and life-1.
  - Otherwise store nx, ny, nvy.
  - If life reaches 0: o_game_over=1 and go directly to S_DONE. Remaining slots are untouched; the spawn is skipped.
- vx and vy are 6-bit two's complement.
- S_SPAWN: frame_cnt==SPAWN_PERIOD-1 -> frame_cnt=0 and spawn, else frame_cnt+1.
  - The spawn uses the lowest-index dead slot: x=64+i_rand[8:0], y=SCREEN_H-1, vx=sext(i_rand[12:9]), vy=-(16+i_rand[15:13]), alive=1.
  - i_rand is sampled in this cycle.
  - No free slot: the spawn is dropped and frame_cnt still wraps.
- A slot cut or exited this frame is free for the same frame's spawn.
- o_rd_* always reflect the registers. Mid-update values are mixed old/new; the renderer reads outside o_busy.

Optional Feature:
BALL_SLOT_COMBO_EN
- Defined: per-update cut counter. The first cut in a frame scores +1; each further cut in the same frame scores +2. The counter clears in S_IDLE.
- Undefined: every cut scores +1; no counter logic.

Test Plan:
- Reset, then idle 10 cycles -> o_life=3, o_score=0, all o_rd_alive=0, o_busy=0.
- SPAWN_PERIOD=4, i_rand=16'h46A0, 4 frame_end pulses -> slot0 alive x=224 y=479 vx=3 vy=-18. o_update_done is 6 cycles after each pulse (NUM_BALLS=4). Next frame -> x=227 y=461 vy=-17.
- Ball at (227,461), blade_valid at (230,470) -> slot0 alive=0, o_score=1, position unchanged. Blade at (260,461) -> no cut.
- Ball y=470 vy=10 -> ny=480 -> alive=0, o_life 3->2. Ball x=2 vx=-5 -> exits left, life-1.
- o_life=1, slots 0 and 1 both exiting the same frame -> o_life=0, o_game_over=1, slot1 still alive and unchanged. Further i_frame_end -> o_busy stays 0.
- i_frame_end while o_busy -> ignored. i_start during S_SCAN -> next cycle all slots dead, score 0, life 3, S_IDLE.
